// File: rtl/ccc_bus_arbiter_pkg.sv
// Shared types and helpers for the CCC bus arbiter: FSM state and the muxed requester bundle.
package ccc_bus_arbiter_pkg;

   typedef enum logic [0:0] {
      Idle    = 1'b0,
      Granted = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic       rx_bit;
      logic       rx_byte;
      logic       tx_bit;
      logic       tx_byte;
      logic       tx_sel_od_pp;
      logic [7:0] tx_value;
   } bus_req_t;

   function automatic logic bus_req_any(bus_req_t r);
      return r.rx_bit | r.rx_byte | r.tx_bit | r.tx_byte;
   endfunction

   function automatic logic bus_req_illegal(bus_req_t r);
      return ((r.rx_bit | r.rx_byte) & (r.tx_bit | r.tx_byte)) |
             (r.rx_bit & r.rx_byte) | (r.tx_bit & r.tx_byte);
   endfunction

   // Keep only the winning request: TX byte > TX bit > RX byte > RX bit.
   function automatic bus_req_t bus_req_prio(bus_req_t r);
      bus_req_t o;
      o         = r;
      o.tx_bit  = r.tx_bit & ~r.tx_byte;
      o.rx_byte = r.rx_byte & ~r.tx_byte & ~r.tx_bit;
      o.rx_bit  = r.rx_bit & ~r.tx_byte & ~r.tx_bit & ~r.rx_byte;
      return o;
   endfunction

endpackage

// File: rtl/ccc_bus_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of i_active scanning upward from i_ptr+1,
// wrapping modulo N.
module ccc_bus_arbiter_rr_pick #(
   parameter int unsigned N    = 3,
   parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    i_active,
   input  logic [IdxW-1:0] i_ptr,
   output logic [IdxW-1:0] o_idx,
   output logic            o_valid
);

   logic [IdxW-1:0] w_cand;

   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      w_cand  = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         w_cand = IdxW'((32'(i_ptr) + i) % N);
         if (!o_valid && i_active[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/ccc_bus_arbiter.sv
// Round-robin owner of the shared bus RX/TX primitive; grants are held while the owner is
// active and forcibly released on STOP or an idle-within-grant watchdog expiry.
module ccc_bus_arbiter
   import ccc_bus_arbiter_pkg::*;
#(
   parameter int unsigned NumReq        = 3,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumReq-1:0]   req_lock_i,
   input  logic [NumReq-1:0]   req_rx_bit_i,
   input  logic [NumReq-1:0]   req_rx_byte_i,
   input  logic [NumReq-1:0]   req_tx_bit_i,
   input  logic [NumReq-1:0]   req_tx_byte_i,
   input  logic [NumReq*8-1:0] req_tx_value_i,
   input  logic [NumReq-1:0]   req_tx_sel_od_pp_i,
   output logic [NumReq-1:0]   gnt_o,
   output logic [NumReq-1:0]   rx_done_o,
   output logic [NumReq-1:0]   tx_done_o,
   output logic [7:0]          rx_data_o,
   output logic                bus_rx_req_bit_o,
   output logic                bus_rx_req_byte_o,
   input  logic                bus_rx_done_i,
   input  logic [7:0]          bus_rx_data_i,
   output logic                bus_tx_req_bit_o,
   output logic                bus_tx_req_byte_o,
   output logic [7:0]          bus_tx_req_value_o,
   output logic                bus_tx_sel_od_pp_o,
   input  logic                bus_tx_done_i,
   input  logic                bus_stop_det_i,
   output logic                timeout_o,
   output logic                proto_err_o
);

   localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam int unsigned PtrW = $clog2(NumReq);
   localparam logic [CntW-1:0] WdogLast = CntW'(TimeoutCycles - 1);

   arb_state_e      r_state;
   logic [PtrW-1:0] r_ptr;
   logic [PtrW-1:0] r_owner;
   logic [CntW-1:0] r_wdog;
   logic            r_timeout;

   bus_req_t          w_req [NumReq];
   logic [NumReq-1:0] w_active;
   bus_req_t          w_own;
   bus_req_t          w_fwd;
   logic              w_own_active;
   logic              w_granted;
   logic              w_done;
   logic              w_count;
   logic              w_expire;
   logic              w_release;
   logic [PtrW-1:0]   w_pick_idx;
   logic              w_pick_valid;

   always_comb begin
      for (int k = 0; k < NumReq; k++) begin
         w_req[k] = '{rx_bit:       req_rx_bit_i[k],
                      rx_byte:      req_rx_byte_i[k],
                      tx_bit:       req_tx_bit_i[k],
                      tx_byte:      req_tx_byte_i[k],
                      tx_sel_od_pp: req_tx_sel_od_pp_i[k],
                      tx_value:     req_tx_value_i[8*k +: 8]};
         w_active[k] = req_lock_i[k] | bus_req_any(w_req[k]);
      end
   end

   ccc_bus_arbiter_rr_pick #(
      .N    (NumReq),
      .IdxW (PtrW)
   ) u_rr_pick (
      .i_active (w_active),
      .i_ptr    (r_ptr),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_valid)
   );

   assign w_own        = w_req[r_owner];
   assign w_fwd        = bus_req_prio(w_own);
   assign w_own_active = w_active[r_owner];
   assign w_granted    = (r_state == Granted);
   assign w_done       = bus_rx_done_i | bus_tx_done_i;
   // Watchdog counts quiet cycles only: no owner request and no done in flight.
   assign w_count      = w_granted & ~bus_req_any(w_own) & ~w_done;
   assign w_expire     = (TimeoutCycles != 0) && w_count && (r_wdog == WdogLast);
   assign w_release    = w_granted & (~w_own_active | bus_stop_det_i | w_expire);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= Idle;
         r_ptr     <= PtrW'(NumReq - 1);
         r_owner   <= '0;
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire & ~bus_stop_det_i & w_own_active;
         case (r_state)
            Idle: begin
               r_wdog <= '0;
               if (w_pick_valid) begin
                  r_owner <= w_pick_idx;
                  r_state <= Granted;
               end
            end
            Granted: begin
               if (w_release) begin
                  r_state <= Idle;
                  r_ptr   <= r_owner;
                  r_wdog  <= '0;
               end else if (w_count && (TimeoutCycles != 0)) begin
                  r_wdog <= r_wdog + CntW'(1);
               end else begin
                  r_wdog <= '0;
               end
            end
            default: r_state <= Idle;
         endcase
      end
   end

   always_comb begin
      gnt_o              = '0;
      rx_done_o          = '0;
      tx_done_o          = '0;
      bus_rx_req_bit_o   = 1'b0;
      bus_rx_req_byte_o  = 1'b0;
      bus_tx_req_bit_o   = 1'b0;
      bus_tx_req_byte_o  = 1'b0;
      bus_tx_req_value_o = '0;
      bus_tx_sel_od_pp_o = 1'b0;
      proto_err_o        = 1'b0;
      if (w_granted) begin
         gnt_o[r_owner]     = 1'b1;
         rx_done_o[r_owner] = bus_rx_done_i;
         tx_done_o[r_owner] = bus_tx_done_i;
         bus_rx_req_bit_o   = w_fwd.rx_bit;
         bus_rx_req_byte_o  = w_fwd.rx_byte;
         bus_tx_req_bit_o   = w_fwd.tx_bit;
         bus_tx_req_byte_o  = w_fwd.tx_byte;
         bus_tx_req_value_o = w_fwd.tx_value;
         bus_tx_sel_od_pp_o = w_fwd.tx_sel_od_pp;
         proto_err_o        = bus_req_illegal(w_own);
      end else begin
         // Nobody owns the bus, so any done is spurious.
         proto_err_o = w_done;
      end
   end

   assign rx_data_o = bus_rx_data_i;
   assign timeout_o = r_timeout;

endmodule

// File: tb/tb_ccc_bus_arbiter.sv
// Self-checking bench for ccc_bus_arbiter: directed scenarios plus randomized traffic compared
// cycle by cycle against a behavioural ownership model.
module tb_ccc_bus_arbiter;

   localparam int N  = 3;
   localparam int TO = 8;

   logic           clk = 1'b0;
   logic           rst_ni = 1'b0;
   logic [N-1:0]   req_lock = '0, req_rx_bit = '0, req_rx_byte = '0;
   logic [N-1:0]   req_tx_bit = '0, req_tx_byte = '0, req_od = '0;
   logic [N*8-1:0] req_tx_value = '0;
   logic           bus_rx_done = 1'b0, bus_tx_done = 1'b0, bus_stop = 1'b0;
   logic [7:0]     bus_rx_data = '0;

   logic [N-1:0] gnt_o, rx_done_o, tx_done_o;
   logic [7:0]   rx_data_o, bus_tx_req_value_o;
   logic         bus_rx_req_bit_o, bus_rx_req_byte_o, bus_tx_req_bit_o, bus_tx_req_byte_o;
   logic         bus_tx_sel_od_pp_o, timeout_o, proto_err_o;

   logic [N-1:0] n_gnt_o, n_rx_done_o, n_tx_done_o;
   logic [7:0]   n_rx_data_o, n_bus_tx_req_value_o;
   logic         n_bus_rx_req_bit_o, n_bus_rx_req_byte_o, n_bus_tx_req_bit_o;
   logic         n_bus_tx_req_byte_o, n_bus_tx_sel_od_pp_o, n_timeout_o, n_proto_err_o;

   int n_cmp = 0;
   int n_err = 0;

   // Model: owner index (-1 = nobody), scan pointer, consecutive quiet cycles, timeout flag.
   int m_owner, m_ptr, m_quiet;
   bit m_tmo;

   always #5 clk = ~clk;

   ccc_bus_arbiter #(.NumReq(N), .TimeoutCycles(TO)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_lock_i(req_lock), .req_rx_bit_i(req_rx_bit),
      .req_rx_byte_i(req_rx_byte), .req_tx_bit_i(req_tx_bit), .req_tx_byte_i(req_tx_byte),
      .req_tx_value_i(req_tx_value), .req_tx_sel_od_pp_i(req_od), .gnt_o(gnt_o),
      .rx_done_o(rx_done_o), .tx_done_o(tx_done_o), .rx_data_o(rx_data_o),
      .bus_rx_req_bit_o(bus_rx_req_bit_o), .bus_rx_req_byte_o(bus_rx_req_byte_o),
      .bus_rx_done_i(bus_rx_done), .bus_rx_data_i(bus_rx_data),
      .bus_tx_req_bit_o(bus_tx_req_bit_o), .bus_tx_req_byte_o(bus_tx_req_byte_o),
      .bus_tx_req_value_o(bus_tx_req_value_o), .bus_tx_sel_od_pp_o(bus_tx_sel_od_pp_o),
      .bus_tx_done_i(bus_tx_done), .bus_stop_det_i(bus_stop), .timeout_o(timeout_o),
      .proto_err_o(proto_err_o)
   );

   ccc_bus_arbiter #(.NumReq(N), .TimeoutCycles(0)) dut_nowd (
      .clk_i(clk), .rst_ni(rst_ni), .req_lock_i(req_lock), .req_rx_bit_i(req_rx_bit),
      .req_rx_byte_i(req_rx_byte), .req_tx_bit_i(req_tx_bit), .req_tx_byte_i(req_tx_byte),
      .req_tx_value_i(req_tx_value), .req_tx_sel_od_pp_i(req_od), .gnt_o(n_gnt_o),
      .rx_done_o(n_rx_done_o), .tx_done_o(n_tx_done_o), .rx_data_o(n_rx_data_o),
      .bus_rx_req_bit_o(n_bus_rx_req_bit_o), .bus_rx_req_byte_o(n_bus_rx_req_byte_o),
      .bus_rx_done_i(bus_rx_done), .bus_rx_data_i(bus_rx_data),
      .bus_tx_req_bit_o(n_bus_tx_req_bit_o), .bus_tx_req_byte_o(n_bus_tx_req_byte_o),
      .bus_tx_req_value_o(n_bus_tx_req_value_o), .bus_tx_sel_od_pp_o(n_bus_tx_sel_od_pp_o),
      .bus_tx_done_i(bus_tx_done), .bus_stop_det_i(bus_stop), .timeout_o(n_timeout_o),
      .proto_err_o(n_proto_err_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit any_req(int k);
      return req_rx_bit[k] | req_rx_byte[k] | req_tx_bit[k] | req_tx_byte[k];
   endfunction

   function automatic bit is_active(int k);
      return req_lock[k] | any_req(k);
   endfunction

   task automatic clear_inputs();
      req_lock = '0; req_rx_bit = '0; req_rx_byte = '0; req_tx_bit = '0; req_tx_byte = '0;
      req_od = '0; req_tx_value = '0; bus_rx_done = 0; bus_tx_done = 0; bus_stop = 0;
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = N - 1; m_quiet = 0; m_tmo = 0;
   endtask

   // Called just after a rising edge; leaves the bench just after a later rising edge.
   task automatic do_reset();
      rst_ni = 1'b0;
      clear_inputs();
      #1;
      check_eq("rst_async_gnt", 32'(gnt_o), 0);
      check_eq("rst_async_txbyte", 32'(bus_tx_req_byte_o), 0);
      bus_rx_data = 8'h5A;
      @(negedge clk);
      check_eq("rst_timeout", 32'(timeout_o), 0);
      check_eq("rst_proto", 32'(proto_err_o), 0);
      check_eq("rst_rxdata", 32'(rx_data_o), 32'h5A);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      model_reset();
   endtask

   // Compare every output against the model for the inputs currently applied.
   task automatic settle();
      logic [N-1:0] e_gnt, e_rxd, e_txd;
      logic [7:0]   e_val;
      logic         e_rb, e_ry, e_tb, e_ty, e_sel, e_perr;
      int           o, nb;
      @(negedge clk);
      o = m_owner;
      e_gnt = '0; e_rxd = '0; e_txd = '0; e_val = '0;
      e_rb = 0; e_ry = 0; e_tb = 0; e_ty = 0; e_sel = 0;
      if (o >= 0) begin
         e_gnt[o] = 1'b1;
         e_rxd[o] = bus_rx_done;
         e_txd[o] = bus_tx_done;
         e_ty  = req_tx_byte[o];
         e_tb  = req_tx_bit[o] & ~e_ty;
         e_ry  = req_rx_byte[o] & ~req_tx_bit[o] & ~req_tx_byte[o];
         e_rb  = req_rx_bit[o] & ~req_rx_byte[o] & ~req_tx_bit[o] & ~req_tx_byte[o];
         e_val = req_tx_value[o*8 +: 8];
         e_sel = req_od[o];
         nb = int'(req_rx_bit[o]) + int'(req_rx_byte[o]) + int'(req_tx_bit[o]) +
              int'(req_tx_byte[o]);
         e_perr = (nb > 1);
      end else begin
         e_perr = bus_rx_done | bus_tx_done;
      end
      check_eq("gnt", 32'(gnt_o), 32'(e_gnt));
      check_eq("rx_done", 32'(rx_done_o), 32'(e_rxd));
      check_eq("tx_done", 32'(tx_done_o), 32'(e_txd));
      check_eq("rx_data", 32'(rx_data_o), 32'(bus_rx_data));
      check_eq("rx_bit", 32'(bus_rx_req_bit_o), 32'(e_rb));
      check_eq("rx_byte", 32'(bus_rx_req_byte_o), 32'(e_ry));
      check_eq("tx_bit", 32'(bus_tx_req_bit_o), 32'(e_tb));
      check_eq("tx_byte", 32'(bus_tx_req_byte_o), 32'(e_ty));
      check_eq("tx_value", 32'(bus_tx_req_value_o), 32'(e_val));
      check_eq("tx_sel", 32'(bus_tx_sel_od_pp_o), 32'(e_sel));
      check_eq("timeout", 32'(timeout_o), 32'(m_tmo));
      check_eq("proto_err", 32'(proto_err_o), 32'(e_perr));
   endtask

   // Advance the ownership model by one clock using the applied inputs, then cross the edge.
   task automatic advance();
      bit act, quiet, expire;
      if (m_owner < 0) begin
         m_tmo = 0;
         m_quiet = 0;
         for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (m_owner < 0 && is_active(k)) m_owner = k;
         end
      end else begin
         act    = is_active(m_owner);
         quiet  = !any_req(m_owner) && !bus_rx_done && !bus_tx_done;
         expire = (TO != 0) && quiet && (m_quiet == TO - 1);
         m_tmo  = expire && !bus_stop && act;
         if (!act || bus_stop || expire) begin
            m_ptr   = m_owner;
            m_owner = -1;
            m_quiet = 0;
         end else begin
            m_quiet = quiet ? m_quiet + 1 : 0;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int unsigned p_req, p_done, p_stop;
      int n_g, n_t;
      model_reset();
      @(posedge clk); #1;

      // Basic grant and same-cycle done routing.
      do_reset();
      req_lock[1] = 1; req_rx_byte[1] = 1;
      settle(); check_eq("basic_idle_gnt", 32'(gnt_o), 0); advance();
      settle(); check_eq("basic_gnt", 32'(gnt_o), 32'b010);
      check_eq("basic_rxbyte", 32'(bus_rx_req_byte_o), 1); advance();
      bus_rx_done = 1; bus_rx_data = 8'hFD;
      settle(); check_eq("basic_rxdone", 32'(rx_done_o), 32'b010);
      check_eq("basic_rxdata", 32'(rx_data_o), 32'hFD); advance();
      bus_rx_done = 0;
      settle(); advance();

      // Watchdog: lock-only owner released after 8 granted cycles; no-watchdog copy holds.
      do_reset();
      req_lock[0] = 1;
      n_g = 0; n_t = 0;
      for (int c = 0; c < 10; c++) begin
         settle();
         if (gnt_o != '0) n_g++;
         if (timeout_o) n_t++;
         advance();
      end
      check_eq("wdog_grant_cycles", 32'(n_g), 8);
      check_eq("wdog_timeout_pulses", 32'(n_t), 1);
      check_eq("nowd_hold", 32'(n_gnt_o), 32'b001);

      // Lock hold on the no-watchdog copy: a locked owner blocks req 0 without leakage.
      do_reset();
      req_lock[1] = 1;
      settle(); advance();
      req_tx_bit[0] = 1;
      for (int c = 0; c < 10; c++) begin
         settle();
         check_eq("hold_gnt", 32'(n_gnt_o), 32'b010);
         check_eq("hold_txbit_leak", 32'(n_bus_tx_req_bit_o), 0);
         advance();
      end
      req_lock[1] = 0;
      settle(); advance();
      settle(); check_eq("hold_idle_gap", 32'(n_gnt_o), 0); advance();
      settle(); check_eq("hold_next_gnt", 32'(n_gnt_o), 32'b001); advance();

      // Illegal combination, then a spurious done while idle.
      do_reset();
      req_lock[2] = 1; req_tx_byte[2] = 1; req_rx_byte[2] = 1;
      settle(); advance();
      for (int c = 0; c < 3; c++) begin
         settle();
         check_eq("perr_txbyte", 32'(bus_tx_req_byte_o), 1);
         check_eq("perr_rxbyte", 32'(bus_rx_req_byte_o), 0);
         check_eq("perr_flag", 32'(proto_err_o), 1);
         advance();
      end
      clear_inputs();
      settle(); advance();
      bus_tx_done = 1;
      settle(); check_eq("idle_txdone", 32'(tx_done_o), 0);
      check_eq("idle_done_perr", 32'(proto_err_o), 1); advance();
      bus_tx_done = 0;

      // STOP abort: release without timeout, next scan starts after the old owner.
      do_reset();
      req_lock[1] = 1; req_tx_byte[1] = 1;
      settle(); advance();
      settle(); advance();
      bus_stop = 1;
      settle(); check_eq("stop_txbyte", 32'(bus_tx_req_byte_o), 1); advance();
      bus_stop = 0; req_lock[0] = 1; req_lock[2] = 1;
      settle(); check_eq("stop_gnt", 32'(gnt_o), 0);
      check_eq("stop_timeout", 32'(timeout_o), 0); advance();
      settle(); check_eq("stop_next_owner", 32'(gnt_o), 32'b100); advance();

      // Randomized traffic in phases of varying intensity.
      do_reset();
      for (int ph = 0; ph < 6; ph++) begin
         case (ph % 3)
            0:       begin p_req = 0;  p_done = 4;  p_stop = 0; end
            1:       begin p_req = 15; p_done = 20; p_stop = 3; end
            default: begin p_req = 40; p_done = 30; p_stop = 6; end
         endcase
         for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
               if ($urandom_range(99) < 8) req_lock[k] = ~req_lock[k];
               req_rx_bit[k]  = ($urandom_range(99) < p_req);
               req_rx_byte[k] = ($urandom_range(99) < p_req);
               req_tx_bit[k]  = ($urandom_range(99) < p_req);
               req_tx_byte[k] = ($urandom_range(99) < p_req);
               req_od[k]      = $urandom_range(1) != 0;
               req_tx_value[k*8 +: 8] = 8'($urandom);
            end
            bus_rx_done = ($urandom_range(99) < p_done);
            bus_tx_done = ($urandom_range(99) < p_done);
            bus_stop    = ($urandom_range(99) < p_stop);
            bus_rx_data = 8'($urandom);
            settle();
            advance();
         end
      end
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
